// File: rtl/video_mode_ctrl.sv
// Video mode selector. Two raw pushbuttons are synchronized and debounced.
// Each press advances a staged 2-bit code. Staged codes reach the outputs only at a frame boundary.
module video_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 742500,
  parameter logic [1:0]  BG_RESET        = 2'b00,
  parameter logic [1:0]  TARGET_RESET    = 2'b00
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_bg_in,
  input  logic       btn_target_in,
  input  logic       new_frame_in,
  input  logic       lock_in,
  output logic [1:0] bg_out,
  output logic [1:0] target_out,
  output logic       pending_out,
  output logic       mode_change_out
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the background button and index 1 is the overlay button.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       press;

  logic [1:0] stg_bg_q, stg_bg_d, stg_tg_q, stg_tg_d;
  logic [1:0] bg_q, bg_d, tg_q, tg_d;
  logic       pend_q, pend_d, mc_q, mc_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= {btn_target_in, btn_bg_in};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // A press is the same edge on which the stable value rises.
  always_comb begin
    stable_d = stable_q;
    press    = '0;
    cnt_d[0] = cnt_q[0];
    cnt_d[1] = cnt_q[1];
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        press[i]    = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stg_bg_d = stg_bg_q + {1'b0, press[0] & ~lock_in};
    stg_tg_d = stg_tg_q + {1'b0, press[1] & ~lock_in};
    bg_d     = new_frame_in ? stg_bg_q : bg_q;
    tg_d     = new_frame_in ? stg_tg_q : tg_q;
    pend_d   = (stg_bg_d != bg_d) || (stg_tg_d != tg_d);
    mc_d     = new_frame_in && ((stg_bg_q != bg_q) || (stg_tg_q != tg_q));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stg_bg_q <= BG_RESET;
      stg_tg_q <= TARGET_RESET;
      bg_q     <= BG_RESET;
      tg_q     <= TARGET_RESET;
      pend_q   <= 1'b0;
      mc_q     <= 1'b0;
    end else begin
      stg_bg_q <= stg_bg_d;
      stg_tg_q <= stg_tg_d;
      bg_q     <= bg_d;
      tg_q     <= tg_d;
      pend_q   <= pend_d;
      mc_q     <= mc_d;
    end
  end

  assign bg_out          = bg_q;
  assign target_out      = tg_q;
  assign pending_out     = pend_q;
  assign mode_change_out = mc_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomized and directed bench for video_mode_ctrl with a history-based reference model.
// Expected outputs are queued per clock edge, and a monitor compares them against the DUT.
module tb_video_mode_ctrl;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_bg = 1'b0;
  logic       btn_tg = 1'b0;
  logic       nf = 1'b0;
  logic       lock = 1'b0;
  logic [1:0] bg_o, tg_o;
  logic       pend_o, mc_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] bg;
    logic [1:0] tg;
    logic       pend;
    logic       mc;
  } exp_t;
  exp_t exp_q[$];

  // Reference state. hist[i][0] holds the first-stage sample. hist[i][k] for k >= 1 holds the second-stage sample from k-1 edges ago.
  bit       hist [2][N+2];
  bit       stable [2];
  int       m_sbg, m_stg, m_bg, m_tg;
  bit       m_pend, m_mc;

  video_mode_ctrl #(
    .DEBOUNCE_CYCLES(N),
    .BG_RESET(2'b00),
    .TARGET_RESET(2'b00)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .btn_bg_in(btn_bg),
    .btn_target_in(btn_tg),
    .new_frame_in(nf),
    .lock_in(lock),
    .bg_out(bg_o),
    .target_out(tg_o),
    .pending_out(pend_o),
    .mode_change_out(mc_o)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit rb, input bit rt, input bit f, input bit lk, input bit r);
    bit raw [2];
    bit pr [2];
    bit all_diff;
    int old_bg, old_tg;
    exp_t e;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        stable[i] = 1'b0;
        for (int k = 0; k < N + 2; k++) hist[i][k] = 1'b0;
      end
      m_sbg = 0; m_stg = 0; m_bg = 0; m_tg = 0;
      m_pend = 1'b0; m_mc = 1'b0;
    end else begin
      raw[0] = rb;
      raw[1] = rt;
      for (int i = 0; i < 2; i++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= N; k++)
          if (hist[i][k] == stable[i]) all_diff = 1'b0;
        pr[i] = 1'b0;
        if (all_diff) begin
          stable[i] = ~stable[i];
          pr[i] = stable[i];
        end
        for (int k = N + 1; k >= 1; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = raw[i];
      end
      old_bg = m_bg;
      old_tg = m_tg;
      if (f) begin
        m_bg = m_sbg;
        m_tg = m_stg;
      end
      m_mc = (m_bg != old_bg) || (m_tg != old_tg);
      if (pr[0] && !lk) m_sbg = (m_sbg + 1) % 4;
      if (pr[1] && !lk) m_stg = (m_stg + 1) % 4;
      m_pend = (m_sbg != m_bg) || (m_stg != m_tg);
    end
    e.bg   = 2'(m_bg);
    e.tg   = 2'(m_tg);
    e.pend = m_pend;
    e.mc   = m_mc;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit b, input bit t, input bit f, input bit lk, input bit r);
    @(negedge clk);
    btn_bg = b;
    btn_tg = t;
    nf     = f;
    lock   = lk;
    rst    = r;
    model_edge(b, t, f, lk, r);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("bg_out", int'(bg_o), int'(e.bg));
        chk("target_out", int'(tg_o), int'(e.tg));
        chk("pending_out", int'(pend_o), int'(e.pend));
        chk("mode_change_out", int'(mc_o), int'(e.mc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hb, ht, run;
    bit vb, vt, lvl;
    // Reset with random buttons.
    for (int c = 0; c < 3; c++) step(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Clean background press, followed by a frame.
    for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Bounce on the target button. High runs last 1-3 cycles.
    lvl = 1'b0;
    for (int c = 0; c < 50; ) begin
      lvl = ~lvl;
      run = $urandom_range(1, 3);
      for (int k = 0; k < run && c < 50; k++) begin
        step(1'b0, lvl, 1'b0, 1'b0, 1'b0);
        c++;
      end
    end
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Four target presses wrap back to the applied value. Five presses advance it by one.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Press and frame pulse on the same edge. The press lands on the 6th edge after the rise.
    for (int c = 1; c <= 12; c++) step(1'b1, 1'b0, (c == 6), 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // A press while locked is dropped.
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Reset mid-debounce, with the button still held afterwards.
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Random traffic.
    hb = 0; ht = 0; vb = 1'b0; vt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hb == 0) begin vb = ~vb; hb = $urandom_range(1, 12); end
      if (ht == 0) begin vt = ~vt; ht = $urandom_range(1, 12); end
      hb--;
      ht--;
      step(vb, vt, ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 499) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Drives the background-select and overlay-select codes consumed by the video mux, from two raw pushbuttons.
- Each button is synchronized and debounced. Each press advances its 2-bit mode code, modulo 4.
- New codes are staged and applied only at a frame boundary, so the display never changes mode mid-frame.

Parameters:
- DEBOUNCE_CYCLES, 742500, consecutive cycles a synchronized input must differ from its stable value before the stable value flips (10 ms at 74.25 MHz); must be >= 2.
- BG_RESET, 2'b00, reset value of the staged and output background code.
- TARGET_RESET, 2'b00, reset value of the staged and output overlay code.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- btn_bg_in  input  1  raw asynchronous button; each press advances the background code
- btn_target_in  input  1  raw asynchronous button; each press advances the overlay code
- new_frame_in  input  1  one-cycle pulse at start of vertical blank
- lock_in  input  1  when high, debounced presses are discarded
- bg_out  output  2  applied background select code
- target_out  output  2  applied overlay select code
- pending_out  output  1  high while a staged code differs from the applied code
- mode_change_out  output  1  one-cycle pulse coincident with an applied-code change

Behaviour:
- Reset (rst_in high at a clock edge) has priority over everything, including mid-debounce and mid-frame:
  - synchronizer flops = 0, stable values = 0, debounce counters = 0;
  - staged and output codes = BG_RESET / TARGET_RESET;
  - pending_out = 0, mode_change_out = 0.
- Synchronizer: two flops per button (s1, s2); s2 feeds the debouncer.
- Debouncer (one per button), counter width $clog2(DEBOUNCE_CYCLES):
  - if s2 == stable: counter <= 0;
  - else if counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0;
  - else counter <= counter+1.
  - Any single-cycle agreement restarts the count.
- Press: the clock edge at which stable goes 0->1. Releases (1->0) produce nothing.
- Staging: on a press with lock_in low, staged code <= staged code + 1, 2-bit wrap (11 -> 00). With lock_in high the press is dropped; debouncing still runs.
- Apply: on an edge with new_frame_in high, bg_out <= staged_bg and target_out <= staged_target. Both use the staged values held before that edge.
- Simultaneous press and new_frame_in: the output takes the pre-press staged value; the increment lands in the staged code and remains pending until the next frame.
- Multiple presses within one frame accumulate. Four presses return the staged code to the applied value, so no change occurs at the frame boundary.
- pending_out: registered; equals (staged_bg != bg_out) || (staged_target != target_out) evaluated on next-state values, i.e. valid the same cycle the registers update.
- mode_change_out: registered; high for exactly one cycle, the first cycle the new bg_out/target_out values are visible, and only if either code actually changed value. If new_frame_in repeats on consecutive cycles, at most one pulse per real change.
- Latency:
  - raw edge to stable flip = 2 + DEBOUNCE_CYCLES cycles, given a clean input;
  - press to staged = same edge;
  - staged to output = the next new_frame_in edge.
- The two buttons are fully independent; presses on both in one cycle update both staged codes.

Test Plan:
1. Reset: assert rst_in 3 cycles with random buttons -> bg_out=00, target_out=00, pending_out=0, mode_change_out=0.
2. Clean bg press (DEBOUNCE_CYCLES=4):
   - btn_bg_in high 20 cycles -> staged bg=01 and pending_out=1 at edge 6 after the rise; bg_out stays 00;
   - then new_frame_in pulse -> bg_out=01, mode_change_out high 1 cycle, pending_out=0.
3. Bounce rejection: btn_target_in toggled with high runs of 1-3 cycles for 50 cycles -> no press, target_out/pending_out unchanged.
4. Wrap: four clean target presses before any frame -> staged target 00; new_frame_in -> target_out=00, no mode_change_out pulse, pending_out=0. Five presses -> target_out=01.
5. Collision: press completes on the same edge as new_frame_in -> bg_out keeps the old value, pending_out=1; next new_frame_in -> bg_out advances by 1, single mode_change_out pulse.
6. Lock and reset:
   - lock_in high during a press -> staged unchanged;
   - rst_in asserted at debounce count 2 -> counter 0, stable 0, and no press occurs after release of reset unless the button is held a further 2+4 cycles.
